wb_arbiter2: RTL

Two-master Wishbone B4 classic arbiter that shares the single system bus (flash emulator, SPRAM memory, mtimer, GPIO) between the CPU and a second master such as a DMA or debug port. It grants bus ownership per Wishbone cycle (`cyc` held), using round-robin when both masters request, and forwards the granted master's signals to the slave side. Slave responses are routed back to the owner only. An optional watchdog terminates cycles that no slave acknowledges.

---
 rtl/wb_pkg.sv | 8 +
 rtl/wb_watchdog.sv | 31 +++
 rtl/wb_arbiter2.sv | 102 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone arbiter types, bus widths and default watchdog limit.
package wb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    localparam int ADR_W       = 32;
    localparam int DAT_W       = 32;
    localparam int SEL_W       = 4;
    localparam int TIMEOUT_DEF = 256;
endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts stalled strobe cycles and raises a one-cycle expiry pulse
// the cycle after TIMEOUT_CYCLES consecutive stalls.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_stb,
    input  logic i_term,
    input  logic i_clr,
    output logic o_expire
);
    logic [15:0] r_cnt;
    logic        r_expire;
    logic        w_stall;
    logic        w_limit;

    assign w_stall  = i_stb & ~i_term & ~i_clr;
    assign w_limit  = r_cnt == 16'(TIMEOUT_CYCLES - 1);
    assign o_expire = r_expire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_expire <= 1'b0;
        end else begin
            r_cnt    <= (w_stall && !w_limit) ? r_cnt + 16'd1 : '0;
            r_expire <= w_stall & w_limit;
        end
    end
endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone B4 classic round-robin arbiter.
// Define WB_ARBITER2_TIMEOUT_EN to add the stalled-slave watchdog.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i
);
    state_t r_state, w_next;
    logic   r_last_grant;
    logic   w_g0, w_g1;
    logic   w_expire, w_wd_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_next != IDLE) r_last_grant <= w_next == GRANT1;
        end
    end

    // The owner keeps the bus until it drops cyc; handover skips IDLE.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (m0_cyc_i && m1_cyc_i) ? (r_last_grant ? GRANT0 : GRANT1) :
                              m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE;
            GRANT0:  w_next = m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE;
            GRANT1:  w_next = m1_cyc_i ? GRANT1 : m0_cyc_i ? GRANT0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_g0 = r_state == GRANT0;
    assign w_g1 = r_state == GRANT1;

    assign s_cyc_o = (w_g0 & m0_cyc_i) | (w_g1 & m1_cyc_i);
    assign s_stb_o = ((w_g0 & m0_stb_i) | (w_g1 & m1_stb_i)) & ~w_expire;
    assign s_we_o  = (w_g0 & m0_we_i) | (w_g1 & m1_we_i);
    assign s_adr_o = w_g0 ? m0_adr_i : w_g1 ? m1_adr_i : '0;
    assign s_sel_o = w_g0 ? m0_sel_i : w_g1 ? m1_sel_i : '0;
    assign s_dat_o = w_g0 ? m0_dat_i : w_g1 ? m1_dat_i : '0;

    // A late slave ack in the expiry cycle takes precedence over the watchdog error.
    assign w_wd_err = w_expire & ~s_ack_i;

    assign m0_dat_o = w_g0 ? s_dat_i : '0;
    assign m0_ack_o = w_g0 & s_ack_i;
    assign m0_err_o = w_g0 & (s_err_i | w_wd_err);
    assign m0_rty_o = w_g0 & s_rty_i;
    assign m1_dat_o = w_g1 ? s_dat_i : '0;
    assign m1_ack_o = w_g1 & s_ack_i;
    assign m1_err_o = w_g1 & (s_err_i | w_wd_err);
    assign m1_rty_o = w_g1 & s_rty_i;

`ifdef WB_ARBITER2_TIMEOUT_EN
    wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_stb    (s_stb_o),
        .i_term   (s_ack_i | s_err_i | s_rty_i),
        .i_clr    (w_next != r_state),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif
endmodule
